// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for a 4-digit common-anode 7-segment display.
// A value is taken in through a load strobe. It is parked in a pending register
// and moved into the shadow register only at a frame boundary, so a frame never
// shows a mix of old and new digits. Each digit slot starts with a blanking gap
// (all anodes off) and then lights the selected digit.
// Optional feature: define LEADING_ZERO_BLANK_EN to turn off leading-zero
// digits 3..1. Digit 0 is always lit.
module seg_scan_ctrl #(
   parameter int PRESCALE     = 50000,  // cycles per digit slot (blank + on)
   parameter int BLANK_CYCLES = 16      // all-off cycles at the start of each slot
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic        load,
   output logic        upd_ack,
   output logic        frame_tick,
   output logic [3:0]  digit_nib,
   output logic [3:0]  an
);

   localparam int CW = $clog2(PRESCALE);

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } state_t;

   state_t      state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [1:0]  d_reg, d_next;
   logic [15:0] pending_reg, pending_next;
   logic        pend_vld_reg, pend_vld_next;
   logic [15:0] shadow_reg, shadow_next;
   logic [3:0]  an_next;
   logic [3:0]  nib_next;
   logic        ack_next;
   logic        tick_next;

   logic [3:0]  lit;        // per-digit enable after leading-zero suppression
   logic        slot_end;   // last ON cycle of the current digit slot
   logic        boundary;   // last ON cycle of digit 3: the frame boundary

   assign slot_end = (state_reg == ON) && (cnt_reg == CW'(PRESCALE - 1));
   assign boundary = slot_end && (d_reg == 2'd3);

   // Digit i is suppressed when shadow nibbles i..3 are all zero. Digit 0 is
   // never suppressed. The result comes from the shadow register, so it only
   // changes at frame boundaries.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lit
`ifdef LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_d0
            assign lit[gi] = 1'b1;
         end else begin : g_dn
            assign lit[gi] = |shadow_reg[15:4*gi];
         end
`else
         assign lit[gi] = 1'b1;
`endif
      end
   endgenerate

   // Next-state logic for the blank/on phase, slot counter, digit index,
   // load handshake and registered outputs.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg + 1'b1;
      d_next        = d_reg;
      pending_next  = pending_reg;
      pend_vld_next = pend_vld_reg;
      shadow_next   = shadow_reg;
      nib_next      = digit_nib;
      ack_next      = 1'b0;
      tick_next     = 1'b0;
      an_next       = 4'b1111;

      case (state_reg)
         BLANK: begin
            if (cnt_reg == CW'(BLANK_CYCLES - 1)) begin
               state_next = ON;
            end
         end
         ON: begin
            if (slot_end) begin
               state_next = BLANK;
               cnt_next   = '0;
               d_next     = d_reg + 2'd1;
            end
         end
         default: begin
            state_next = BLANK;
            cnt_next   = '0;
         end
      endcase

      // A load in the boundary cycle goes straight to the shadow register.
      // Otherwise the pending value (latest load wins) is committed.
      if (boundary) begin
         tick_next = 1'b1;
         if (load) begin
            shadow_next   = data_in;
            pending_next  = data_in;
            pend_vld_next = 1'b0;
            ack_next      = 1'b1;
         end else if (pend_vld_reg) begin
            shadow_next   = pending_reg;
            pend_vld_next = 1'b0;
            ack_next      = 1'b1;
         end
      end else if (load) begin
         pending_next  = data_in;
         pend_vld_next = 1'b1;
      end

      // The nibble is chosen on entry to BLANK and held for the whole slot.
      if (slot_end) begin
         nib_next = shadow_next[{d_next, 2'b00} +: 4];
      end

      if ((state_next == ON) && lit[d_next]) begin
         an_next = ~(4'b0001 << d_next);
      end
   end

   // State and output registers. Reset clears everything and drops any pending load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= BLANK;
         cnt_reg      <= '0;
         d_reg        <= 2'd0;
         pending_reg  <= 16'h0000;
         pend_vld_reg <= 1'b0;
         shadow_reg   <= 16'h0000;
         an           <= 4'b1111;
         digit_nib    <= 4'h0;
         upd_ack      <= 1'b0;
         frame_tick   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         d_reg        <= d_next;
         pending_reg  <= pending_next;
         pend_vld_reg <= pend_vld_next;
         shadow_reg   <= shadow_next;
         an           <= an_next;
         digit_nib    <= nib_next;
         upd_ack      <= ack_next;
         frame_tick   <= tick_next;
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode 7-segment display. Latches a 16-bit hex value through a load handshake, holds it in a shadow register updated only at frame boundaries (no tearing), and sequences one nibble at a time into the shared hex-to-7-segment decoder while driving the active-low digit anodes. A blanking gap before every digit prevents ghosting. Sits between the PS/2 key-code path and the display decoder.

## Interface
- PRESCALE, 50000: clock cycles per digit slot (blank + on); must be ≥ 4.
- BLANK_CYCLES, 16: cycles of all-anodes-off at the start of each slot; 1 ≤ BLANK_CYCLES < PRESCALE.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  16  value to display; nibble [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- load  in  1  one-cycle strobe; samples data_in.
- upd_ack  out  1  one-cycle pulse when a loaded value enters the shadow register.
- frame_tick  out  1  one-cycle pulse at the end of every digit-3 slot.
- digit_nib  out  4  nibble for the decoder.
- an  out  4  anode enables, active-low; an[i] drives digit i.

## Operation
- Registers: pending[15:0], pend_vld, shadow[15:0], digit index d[1:0], slot counter cnt, state ∈ {BLANK, ON}.
- Slot: BLANK for BLANK_CYCLES cycles (an = 4'b1111), then ON for PRESCALE−BLANK_CYCLES cycles (an = ~(1<<d) unless suppressed).
- BLANK→ON when cnt reaches BLANK_CYCLES−1; ON→BLANK when cnt reaches PRESCALE−1; cnt clears and d increments mod 4 at ON→BLANK.
- digit_nib = shadow[4d+3:4d], updated at the BLANK entry edge and held stable through the whole slot.
- load: pending ← data_in, pend_vld ← 1. Load while pend_vld already set overwrites pending (latest wins); only one upd_ack results.
- Frame boundary = ON→BLANK transition with d = 3. At that edge: frame_tick = 1; if load asserted the same cycle, shadow ← data_in directly (bypass), pend_vld ← 0, upd_ack = 1; else if pend_vld, shadow ← pending, pend_vld ← 0, upd_ack = 1.
- Digit 0 of the new frame shows the new shadow value.
- Reset (any time, including mid-slot): state BLANK, cnt 0, d 0, an 4'b1111, digit_nib 0, shadow 0, pending 0, pend_vld 0, upd_ack 0, frame_tick 0. Pending loads are discarded.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Load-to-display latency: from load until the next frame boundary, at most 4·PRESCALE cycles, plus one PRESCALE·0 + BLANK_CYCLES cycles until digit 0 lights.
- upd_ack and frame_tick asserted in the cycle after the boundary edge, for exactly one cycle.
- Frame period exactly 4·PRESCALE cycles; an never has more than one bit low; an = 4'b1111 for BLANK_CYCLES cycles between any two lit digits.
- First lit digit after reset release: digit 0, at cycle BLANK_CYCLES.

## Configuration
- LEADING_ZERO_BLANK_EN defined: during ON, digit i ∈ {3,2,1} keeps an[i] = 1 if shadow nibbles i..3 are all zero; digit 0 always lit. Suppression computed from shadow, so it changes only at frame boundaries.
- Not defined: all four digits always lit during their ON phase (zeros shown as "0").

## Test plan
- PRESCALE=8, BLANK_CYCLES=2, reset mid-slot → all outputs at reset values immediately; after release an sequence per slot 1111,1111,1110×6, then 1111,1111,1101×6, … ; frame_tick every 32 cycles.
- load data_in=16'h1A3F → upd_ack one cycle at next frame boundary; digit_nib sequence F, 3, A, 1 in digits 0–3.
- Two loads (16'h1111 then 16'h2222) within one frame → single upd_ack; display shows 2222.
- load 16'h00C5 asserted in the exact boundary cycle → bypass, upd_ack same boundary, next frame shows 00C5.
- LEADING_ZERO_BLANK_EN, shadow 16'h00C5 → an[3], an[2] stay 1 in their slots; shadow 16'h0000 → only digit 0 lit showing 0.
- Over 3 frames, check an never has two zero bits and every lit phase is preceded by ≥2 cycles of 1111.
